score_seg_display: RTL and testbench

//  Downstream consumer of the game-logic score. Converts the 16-bit binary score to 4 BCD digits

---
 rtl/score_seg_display.sv | 164 ++++++++++++++++
 tb/tb_score_seg_display.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/score_seg_display.sv
// Binary score -> BCD (sequential double-dabble) -> Basys3 4-digit multiplexed 7-seg driver.
// bcd lands 18 edges after a new score is captured; display outputs refresh once per digit slot.
module score_seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        gm_clk,
  input  logic        gm_rst,
  input  logic [15:0] score,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [15:0]    r_last_score;
  logic           r_ovf;
  logic [31:0]    r_shift;
  logic [31:0]    w_adj;
  logic [3:0]     r_iter;
  logic [15:0]    r_result;
  logic [15:0]    r_bcd;
  logic [CW-1:0]  r_ref_cnt;
  logic [1:0]     r_idx;
  logic [6:0]     r_seg;
  logic [3:0]     r_an;
  logic           r_dp;

  logic           w_changed;
  logic           w_sat;
  logic           w_busy;
  logic           w_load;
  logic           w_shift_en;
  logic           w_done;
  logic           w_wrap;
  logic [3:0]     w_digit;
  logic           w_blank;
  logic [6:0]     w_seg;

  assign w_changed = (score != r_last_score);
  assign w_sat     = (score > 16'd9999);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge gm_clk or posedge gm_rst) begin
    if (gm_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_changed) w_next = S_SHIFT;
      S_SHIFT: if (r_iter == 4'd15) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b0;
    w_load     = 1'b0;
    w_shift_en = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE:  w_load = w_changed;
      S_SHIFT: begin w_busy = 1'b1; w_shift_en = 1'b1; end
      S_DONE:  begin w_busy = 1'b1; w_done = 1'b1; end
      default: ;
    endcase
  end

  // Add-3 correction on the four BCD nibbles before each shift.
  always_comb begin
    w_adj = r_shift;
    for (int i = 4; i < 8; i++) begin
      if (r_shift[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_shift[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge gm_clk or posedge gm_rst) begin
    if (gm_rst) begin
      r_last_score <= 16'h0000;
      r_ovf        <= 1'b0;
      r_shift      <= 32'h0;
      r_iter       <= 4'd0;
      r_result     <= 16'h0000;
      r_bcd        <= 16'h0000;
    end else begin
      if (w_load) begin
        r_last_score <= score;
        r_ovf        <= w_sat;
        r_shift      <= {16'h0000, w_sat ? 16'd9999 : score};
        r_iter       <= 4'd0;
      end else if (w_shift_en) begin
        r_shift <= {w_adj[30:0], 1'b0};
        r_iter  <= r_iter + 4'd1;
      end
      if (w_done) r_result <= r_shift[31:16];
      r_bcd <= r_result;
    end
  end

  assign w_wrap  = (r_ref_cnt == CW'(REFRESH_DIV - 1));
  assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd1:    w_blank = (r_bcd[15:4] == 12'h000);
      2'd2:    w_blank = (r_bcd[15:8] == 8'h00);
      2'd3:    w_blank = (r_bcd[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
    w_seg = (BLANK_LZ && w_blank) ? 7'h7F : seg_decode(w_digit);
  end

  // seg/an/dp load together at the slot boundary so no digit ever sees another's segments.
  always_ff @(posedge gm_clk or posedge gm_rst) begin
    if (gm_rst) begin
      r_ref_cnt <= '0;
      r_idx     <= 2'd0;
      r_seg     <= 7'h7F;
      r_an      <= 4'hF;
      r_dp      <= 1'b1;
    end else begin
      r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + CW'(1);
      if (w_wrap) begin
        r_idx <= r_idx + 2'd1;
        r_seg <= w_seg;
        r_an  <= ~(4'b0001 << r_idx);
        r_dp  <= ~((r_idx == 2'd0) && r_ovf);
      end
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign dp   = r_dp;
  assign bcd  = r_bcd;
  assign busy = w_busy;

endmodule

// File: tb/tb_score_seg_display.sv
// Bench for score_seg_display: queued expected BCD results checked by an independent monitor,
// plus directed checks of the scanned display, saturation dp, blanking and async reset abort.
module tb_score_seg_display;

  logic        clk;
  logic        rst;
  logic [15:0] score;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic        busy;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          errors;
  int          cyc;
  int          run;
  logic [15:0] prev_bcd;

  score_seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .gm_clk(clk),
    .gm_rst(rst),
    .score(score),
    .seg(seg),
    .dp(dp),
    .an(an),
    .bcd(bcd),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: busy-run length per conversion and every change of bcd against the queue.
  always @(negedge clk) begin
    if (rst) begin
      run      = 0;
      prev_bcd = bcd;
    end else begin
      if (busy) run++;
      else if (run != 0) begin
        check("busy_len", 32'(run), 32'd17);
        run = 0;
      end
      if (bcd !== prev_bcd) begin
        if (q.size() == 0) check("bcd_unexpected", 32'(bcd), 32'(prev_bcd));
        else begin
          exp_t e;
          e = q.pop_front();
          check("bcd_val", 32'(bcd), 32'(e.val));
          check("bcd_lat", 32'(cyc), 32'(e.due));
        end
        prev_bcd = bcd;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic sync_an(input logic [3:0] target, input int limit);
    int i;
    for (i = 0; i < limit && an !== target; i++) @(negedge clk);
    check("sync_an", 32'(an), 32'(target));
  endtask

  task automatic convert(input logic [15:0] s, input logic [15:0] expv);
    score = s;
    q.push_back('{expv, cyc + 19});
    drain(60);
  endtask

  task automatic slot(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    check({name, "_an"}, 32'(an), 32'(ea));
    check({name, "_seg"}, 32'(seg), 32'(es));
    check({name, "_dp"}, 32'(dp), 32'(ed));
  endtask

  initial begin
    int c;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    score  = 16'd0;
    tick(2);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0);
    rst = 1'b0;

    // score stays 0: no conversion, digit 0 shows '0', digit 1 blanked but driven
    tick(3);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_bcd", 32'(bcd), 32'h0);
    sync_an(4'b1110, 20);
    slot("zero_d0", 4'b1110, 7'h40, 1'b1);
    tick(4);
    slot("zero_d1", 4'b1101, 7'h7F, 1'b1);

    convert(16'd1234, 16'h1234);

    convert(16'd10000, 16'h9999);
    tick(16);
    sync_an(4'b1110, 20);
    slot("ovf_d0", 4'b1110, 7'h10, 1'b0);
    tick(4);
    slot("ovf_d1", 4'b1101, 7'h10, 1'b1);
    tick(4);
    slot("ovf_d2", 4'b1011, 7'h10, 1'b1);
    tick(4);
    slot("ovf_d3", 4'b0111, 7'h10, 1'b1);

    convert(16'd42, 16'h0042);
    tick(16);
    sync_an(4'b1110, 20);
    slot("s42_d0", 4'b1110, 7'h24, 1'b1);
    tick(4);
    slot("s42_d1", 4'b1101, 7'h19, 1'b1);
    tick(4);
    slot("s42_d2", 4'b1011, 7'h7F, 1'b1);
    tick(4);
    slot("s42_d3", 4'b0111, 7'h7F, 1'b1);

    // change arrives two cycles into SHIFT: first result 55, second conversion right after
    score = 16'd55;
    c = cyc;
    q.push_back('{16'h0055, c + 19});
    q.push_back('{16'h9999, c + 37});
    tick(3);
    score = 16'd9999;
    drain(80);

    convert(16'd507, 16'h0507);
    tick(16);
    sync_an(4'b1110, 20);
    slot("s507_d0", 4'b1110, 7'h78, 1'b1);
    tick(4);
    slot("s507_d1", 4'b1101, 7'h40, 1'b1);
    tick(4);
    slot("s507_d2", 4'b1011, 7'h12, 1'b1);
    tick(4);
    slot("s507_d3", 4'b0111, 7'h7F, 1'b1);

    // async reset mid-SHIFT, away from any clock edge
    score = 16'd777;
    tick(5);
    #2 rst = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_bcd", 32'(bcd), 32'h0);
    check("arst_dp", 32'(dp), 32'd1);
    tick(2);
    rst = 1'b0;
    q.push_back('{16'h0777, cyc + 19});
    drain(60);

    tick(4);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
